arm_hazard_scoreboard: RTL and testbench

//  Consumes the decode-stage register-use interface: read mask, read reg numbers, rd write enable.

---
 rtl/arm_hazard_scoreboard.sv | 147 ++++++++++++++
 tb/tb_arm_hazard_scoreboard.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm_hazard_scoreboard.sv
// ============================================================================
// Module   : arm_hazard_scoreboard
// Purpose  : Decode-stage hazard scoreboard. Tracks the destination
//            registers of the instructions in EX, MEM and WB. Produces the
//            per-operand forwarding selects, the load-use stall, the issue
//            strobe, and the SWI halt drain sequencing.
// Ports    : clk, rst_b (async, active low)
//            id_valid, id_read_mask[2:0], id_read_reg0/1/2[3:0],
//            id_rd_we, id_rd_num[3:0], id_is_load, id_halt, flush  (inputs)
//            stall, issue, fwd_sel0/1/2[1:0], draining, halted     (outputs)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module arm_hazard_scoreboard #(
    parameter int DEPTH = 3,
    parameter int NOPS  = 3
) (
    input  logic       clk,
    input  logic       rst_b,
    input  logic       id_valid,
    input  logic [2:0] id_read_mask,
    input  logic [3:0] id_read_reg0,
    input  logic [3:0] id_read_reg1,
    input  logic [3:0] id_read_reg2,
    input  logic       id_rd_we,
    input  logic [3:0] id_rd_num,
    input  logic       id_is_load,
    input  logic       id_halt,
    input  logic       flush,
    output logic       stall,
    output logic       issue,
    output logic [1:0] fwd_sel0,
    output logic [1:0] fwd_sel1,
    output logic [1:0] fwd_sel2,
    output logic       draining,
    output logic       halted
);

    typedef struct packed {
        logic       v;
        logic       we;
        logic [3:0] rd;
        logic       ld;
    } entry_t;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    entry_t ent_q [DEPTH];
    entry_t ent_d [DEPTH];
    state_t state_q;
    state_t state_d;

    logic [3:0]      rd_reg  [NOPS];
    logic [NOPS-1:0] match   [DEPTH];
    logic [1:0]      fwd_sel [NOPS];
    logic            load_use;
    logic            pipe_empty_next;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= '0;
            end
            state_q <= ST_RUN;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                ent_q[k] <= ent_d[k];
            end
            state_q <= state_d;
        end
    end

    always_comb begin
        rd_reg[0] = id_read_reg0;
        rd_reg[1] = id_read_reg1;
        rd_reg[2] = id_read_reg2;

        // R15 reads return the PC value from decode, so they never hazard.
        for (int k = 0; k < DEPTH; k++) begin
            for (int i = 0; i < NOPS; i++) begin
                match[k][i] = ent_q[k].v && ent_q[k].we && id_read_mask[i]
                              && (ent_q[k].rd == rd_reg[i]) && (rd_reg[i] != 4'hf);
            end
        end

        // Walk oldest to youngest so the youngest matching stage wins.
        for (int i = 0; i < NOPS; i++) begin
            fwd_sel[i] = 2'b00;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (match[k][i]) begin
                    fwd_sel[i] = 2'(k + 1);
                end
            end
        end

        load_use = (|match[0]) && ent_q[0].ld;

        case (state_q)
            ST_RUN:  stall = id_valid && load_use;
            default: stall = id_valid;
        endcase

        // Gated by rst_b so the strobe is quiet while reset is held.
        issue = rst_b && id_valid && !stall && !flush && (state_q == ST_RUN);

        // The scoreboard shifts every cycle; a non-issuing cycle inserts a bubble.
        ent_d[0].v  = issue;
        ent_d[0].we = issue && id_rd_we && !id_halt;
        ent_d[0].rd = issue ? id_rd_num : 4'h0;
        ent_d[0].ld = issue && id_is_load;
        for (int k = 1; k < DEPTH; k++) begin
            ent_d[k] = ent_q[k-1];
        end

        // Looking at the post-shift contents lets halted rise on the same
        // edge that the SWI leaves WB.
        pipe_empty_next = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            if (ent_d[k].v) begin
                pipe_empty_next = 1'b0;
            end
        end

        state_d = state_q;
        case (state_q)
            ST_RUN:   if (issue && id_halt) state_d = ST_DRAIN;
            ST_DRAIN: if (pipe_empty_next)  state_d = ST_DONE;
            ST_DONE:  state_d = ST_DONE;
            default:  state_d = ST_RUN;
        endcase

        draining = (state_q == ST_DRAIN);
        halted   = (state_q == ST_DONE);
    end

    assign fwd_sel0 = fwd_sel[0];
    assign fwd_sel1 = fwd_sel[1];
    assign fwd_sel2 = fwd_sel[2];

endmodule

`default_nettype wire

// File: tb/tb_arm_hazard_scoreboard.sv
// ============================================================================
// Module   : tb_arm_hazard_scoreboard
// Purpose  : Directed, self-checking bench for arm_hazard_scoreboard.
//            Observed vector = {stall, issue, fwd_sel0, fwd_sel1, fwd_sel2,
//            draining, halted}, compared against hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_arm_hazard_scoreboard;

    logic       clk;
    logic       rst_b;
    logic       id_valid;
    logic [2:0] id_read_mask;
    logic [3:0] id_read_reg0;
    logic [3:0] id_read_reg1;
    logic [3:0] id_read_reg2;
    logic       id_rd_we;
    logic [3:0] id_rd_num;
    logic       id_is_load;
    logic       id_halt;
    logic       flush;
    logic       stall;
    logic       issue;
    logic [1:0] fwd_sel0;
    logic [1:0] fwd_sel1;
    logic [1:0] fwd_sel2;
    logic       draining;
    logic       halted;

    int         nvec;
    int         nfail;
    logic [9:0] exp_v;
    logic [9:0] obs;

    assign obs = {stall, issue, fwd_sel0, fwd_sel1, fwd_sel2, draining, halted};

    arm_hazard_scoreboard dut (
        .clk          (clk),
        .rst_b        (rst_b),
        .id_valid     (id_valid),
        .id_read_mask (id_read_mask),
        .id_read_reg0 (id_read_reg0),
        .id_read_reg1 (id_read_reg1),
        .id_read_reg2 (id_read_reg2),
        .id_rd_we     (id_rd_we),
        .id_rd_num    (id_rd_num),
        .id_is_load   (id_is_load),
        .id_halt      (id_halt),
        .flush        (flush),
        .stall        (stall),
        .issue        (issue),
        .fwd_sel0     (fwd_sel0),
        .fwd_sel1     (fwd_sel1),
        .fwd_sel2     (fwd_sel2),
        .draining     (draining),
        .halted       (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic v, input logic [2:0] m,
                         input logic [3:0] a, input logic [3:0] b, input logic [3:0] c,
                         input logic we, input logic [3:0] rd,
                         input logic ld, input logic hlt, input logic fl);
        id_valid     = v;
        id_read_mask = m;
        id_read_reg0 = a;
        id_read_reg1 = b;
        id_read_reg2 = c;
        id_rd_we     = we;
        id_rd_num    = rd;
        id_is_load   = ld;
        id_halt      = hlt;
        flush        = fl;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_drain();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_b = 1'b0;
        drive(1, 3'b111, 1, 2, 3, 1, 4, 0, 0, 0);
        step();
        exp_v = 10'b0_0_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL reset_outputs got %b want %b", obs, exp_v); end
        rst_b = 1'b1;
        idle_drain();
    endtask

    // T1: ADD r1 ; SUB r2,r1,r3 -> EX forward, no stall
    task automatic test_ex_forward();
        drive(1, 3'b011, 2, 3, 0, 1, 1, 0, 0, 0);
        exp_v = 10'b0_1_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t1_add got %b want %b", obs, exp_v); end
        step();
        drive(1, 3'b011, 1, 3, 0, 1, 2, 0, 0, 0);
        exp_v = 10'b0_1_01_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t1_sub_fwd got %b want %b", obs, exp_v); end
        step();
        idle_drain();
    endtask

    // T2: LDR r4 ; ADD r5,r4,r4 -> one bubble, then MEM forward on both
    task automatic test_load_use();
        drive(1, 3'b001, 6, 0, 0, 1, 4, 1, 0, 0);
        step();
        drive(1, 3'b011, 4, 4, 0, 1, 5, 0, 0, 0);
        exp_v = 10'b1_0_01_01_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t2_stall got %b want %b", obs, exp_v); end
        step();
        exp_v = 10'b0_1_10_10_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t2_after_bubble got %b want %b", obs, exp_v); end
        step();
        idle_drain();
    endtask

    // T3: youngest wins; plus a WB-only forward with a masked-off operand
    task automatic test_priority();
        drive(1, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        drive(1, 3'b000, 0, 0, 0, 1, 2, 0, 0, 0);
        step();
        drive(1, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        drive(1, 3'b111, 1, 2, 1, 0, 0, 0, 0, 0);
        exp_v = 10'b0_1_01_10_01_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t3_youngest got %b want %b", obs, exp_v); end
        step();
        idle_drain();
        drive(1, 3'b000, 0, 0, 0, 1, 7, 0, 0, 0);
        step();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        step();
        drive(1, 3'b110, 7, 7, 7, 0, 0, 0, 0, 0);
        exp_v = 10'b0_1_00_11_11_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t3_wb_masked got %b want %b", obs, exp_v); end
        step();
        idle_drain();
    endtask

    // T4: R15 never hazards; non-writers never match
    task automatic test_r15_nowrite();
        drive(1, 3'b000, 0, 0, 0, 1, 15, 1, 0, 0);
        step();
        drive(1, 3'b001, 15, 0, 0, 0, 0, 0, 0, 0);
        exp_v = 10'b0_1_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t4_r15 got %b want %b", obs, exp_v); end
        step();
        drive(1, 3'b000, 0, 0, 0, 0, 3, 0, 0, 0);
        step();
        drive(1, 3'b001, 3, 0, 0, 1, 6, 0, 0, 0);
        exp_v = 10'b0_1_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t4_nowrite got %b want %b", obs, exp_v); end
        step();
        idle_drain();
    endtask

    // Flush suppresses issue but still reports stall; the load is not squashed
    task automatic test_flush();
        drive(1, 3'b000, 0, 0, 0, 1, 4, 1, 0, 0);
        step();
        drive(1, 3'b001, 4, 0, 0, 1, 5, 0, 0, 1);
        exp_v = 10'b1_0_01_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL flush_stall got %b want %b", obs, exp_v); end
        step();
        drive(1, 3'b001, 4, 0, 0, 1, 5, 0, 0, 0);
        exp_v = 10'b0_1_10_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL flush_load_kept got %b want %b", obs, exp_v); end
        step();
        idle_drain();
    endtask

    // flush+halt: no transition; load-use+halt: stall first, SWI issues later
    task automatic test_halt_combos();
        drive(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 1);
        exp_v = 10'b0_0_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL flush_halt got %b want %b", obs, exp_v); end
        step();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = 10'b0_0_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL flush_halt_norun got %b want %b", obs, exp_v); end
        drive(1, 3'b000, 0, 0, 0, 1, 4, 1, 0, 0);
        step();
        drive(1, 3'b001, 4, 0, 0, 0, 0, 0, 1, 0);
        exp_v = 10'b1_0_01_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL loaduse_halt_stall got %b want %b", obs, exp_v); end
        step();
        exp_v = 10'b0_1_10_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL loaduse_halt_issue got %b want %b", obs, exp_v); end
        step();
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = 10'b0_0_00_00_00_1_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL loaduse_halt_drain got %b want %b", obs, exp_v); end
    endtask

    // T5: SWI behind two ALU ops -> 3 cycles draining, then halted forever
    task automatic test_drain();
        rst_b = 1'b0;
        #1;
        rst_b = 1'b1;
        drive(1, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        drive(1, 3'b000, 0, 0, 0, 1, 2, 0, 0, 0);
        step();
        drive(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0);
        exp_v = 10'b0_1_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t5_swi_issue got %b want %b", obs, exp_v); end
        step();
        drive(1, 3'b000, 0, 0, 0, 1, 3, 0, 0, 0);
        for (int c = 0; c < 3; c++) begin
            exp_v = 10'b1_0_00_00_00_1_0;
            nvec++;
            if (obs !== exp_v) begin nfail++; $display("FAIL t5_draining_c%0d got %b want %b", c, obs, exp_v); end
            step();
        end
        exp_v = 10'b1_0_00_00_00_0_1;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t5_halted got %b want %b", obs, exp_v); end
        repeat (2) step();
        exp_v = 10'b1_0_00_00_00_0_1;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t5_halted_sticky got %b want %b", obs, exp_v); end
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        exp_v = 10'b0_0_00_00_00_0_1;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t5_halted_idle got %b want %b", obs, exp_v); end
    endtask

    // T6: async reset in DRAIN wipes everything; no stale forwarding
    task automatic test_reset_mid_drain();
        rst_b = 1'b0;
        #1;
        rst_b = 1'b1;
        drive(1, 3'b000, 0, 0, 0, 1, 1, 0, 0, 0);
        step();
        drive(1, 3'b000, 0, 0, 0, 0, 0, 0, 1, 0);
        step();
        drive(1, 3'b001, 1, 0, 0, 1, 2, 0, 0, 0);
        exp_v = 10'b1_0_10_00_00_1_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t6_pre_reset got %b want %b", obs, exp_v); end
        #2;
        rst_b = 1'b0;
        #1;
        exp_v = 10'b0_0_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t6_in_reset got %b want %b", obs, exp_v); end
        step();
        rst_b = 1'b1;
        #1;
        exp_v = 10'b0_1_00_00_00_0_0;
        nvec++;
        if (obs !== exp_v) begin nfail++; $display("FAIL t6_after_reset got %b want %b", obs, exp_v); end
        step();
    endtask

    initial begin
        nvec  = 0;
        nfail = 0;
        rst_b = 1'b0;
        drive(0, 3'b000, 0, 0, 0, 0, 0, 0, 0, 0);
        step();
        test_reset();
        test_ex_forward();
        test_load_use();
        test_priority();
        test_r15_nowrite();
        test_flush();
        test_halt_combos();
        test_drain();
        test_reset_mid_drain();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule

`default_nettype wire
